// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

  localparam int ADDR_W = 32;
  localparam logic [ADDR_W-1:0] PC_INC = ADDR_W'(4);

  typedef enum logic [1:0] {
    RST,
    REQ,
    WAIT,
    HOLD
  } fetch_state_t;

  function automatic logic [ADDR_W-1:0] wordAlign(input logic [ADDR_W-1:0] addr);
    return addr & ~ADDR_W'(3);
  endfunction

endpackage

// File: rtl/fetch_sequencer_pc_update.sv
// Fetch PC register: reset vector, redirect load or word increment.
module pc_update
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_q, pc_d;

  // A redirect always wins over the sequential increment.
  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = wordAlign(target);
    end else if (inc) begin
      pc_d = pc_q + PC_INC;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= wordAlign(RESET_VECTOR);
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: request/wait/hold FSM with branch redirect.
// Define FETCH_TIMEOUT_EN to add a wait-state timeout that pulses fetch_err.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_VECTOR   = 32'h0000_0000,
  parameter int                TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              stall,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [ADDR_W-1:0] imem_rdata,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [ADDR_W-1:0] pc,
  output logic              fetch_err
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] instrPc_q, instrPc_d;
  logic              instrValid_q, instrValid_d;
  logic              redirectPending_q, redirectPending_d;
  logic [ADDR_W-1:0] redirectTarget_q, redirectTarget_d;
  logic              pcLoad, pcInc;
  logic [ADDR_W-1:0] pcTarget, alignedTarget;

  assign alignedTarget = wordAlign(branch_target);

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] timeoutCnt_q, timeoutCnt_d;
  logic             fetchErr_q, fetchErr_d;
  logic             timeoutHit;

  assign timeoutHit = (state_q == WAIT) && !imem_ack && (timeoutCnt_q == CNT_LAST);
  assign fetch_err  = fetchErr_q;
`else
  assign fetch_err = 1'b0;
`endif

  always_comb begin
    state_d           = state_q;
    instr_d           = instr_q;
    instrPc_d         = instrPc_q;
    instrValid_d      = instrValid_q;
    redirectPending_d = redirectPending_q;
    redirectTarget_d  = redirectTarget_q;
    pcLoad            = 1'b0;
    pcInc             = 1'b0;
    pcTarget          = alignedTarget;
    imem_req          = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    fetchErr_d        = 1'b0;
    timeoutCnt_d      = '0;
`endif

    case (state_q)
      RST: state_d = REQ;

      REQ, WAIT: begin
        imem_req = 1'b1;
        // A branch arriving with the ack (or before any wait) restarts at once.
        if (branch_valid && (imem_ack || state_q == REQ)) begin
          pcLoad            = 1'b1;
          instrValid_d      = 1'b0;
          redirectPending_d = 1'b0;
          state_d           = REQ;
        end else if (branch_valid) begin
          redirectPending_d = 1'b1;
          redirectTarget_d  = alignedTarget;
        end else if (imem_ack && redirectPending_q) begin
          pcLoad            = 1'b1;
          pcTarget          = redirectTarget_q;
          redirectPending_d = 1'b0;
          state_d           = REQ;
        end else if (imem_ack) begin
          instr_d      = imem_rdata;
          instrPc_d    = pc;
          instrValid_d = 1'b1;
          pcInc        = 1'b1;
          state_d      = HOLD;
        end else begin
          state_d = WAIT;
        end
      end

      HOLD: begin
        if (branch_valid) begin
          pcLoad       = 1'b1;
          instrValid_d = 1'b0;
          state_d      = REQ;
        end else if (!stall) begin
          instrValid_d = 1'b0;
          state_d      = REQ;
        end
      end

      default: state_d = RST;
    endcase

`ifdef FETCH_TIMEOUT_EN
    if (state_q == WAIT && state_d == WAIT) begin
      timeoutCnt_d = timeoutCnt_q + CNT_W'(1);
    end
    // Retry from the same pc, but never lose a redirect that was latched meanwhile.
    if (timeoutHit) begin
      fetchErr_d   = 1'b1;
      timeoutCnt_d = '0;
      state_d      = REQ;
      if (redirectPending_d) begin
        pcLoad            = 1'b1;
        pcTarget          = redirectTarget_d;
        redirectPending_d = 1'b0;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= RST;
      instr_q           <= '0;
      instrPc_q         <= '0;
      instrValid_q      <= 1'b0;
      redirectPending_q <= 1'b0;
      redirectTarget_q  <= '0;
`ifdef FETCH_TIMEOUT_EN
      timeoutCnt_q      <= '0;
      fetchErr_q        <= 1'b0;
`endif
    end else begin
      state_q           <= state_d;
      instr_q           <= instr_d;
      instrPc_q         <= instrPc_d;
      instrValid_q      <= instrValid_d;
      redirectPending_q <= redirectPending_d;
      redirectTarget_q  <= redirectTarget_d;
`ifdef FETCH_TIMEOUT_EN
      timeoutCnt_q      <= timeoutCnt_d;
      fetchErr_q        <= fetchErr_d;
`endif
    end
  end

  pc_update #(
    .RESET_VECTOR(RESET_VECTOR)
  ) u_pc_update (
    .clk   (clk),
    .reset (reset),
    .load  (pcLoad),
    .inc   (pcInc),
    .target(pcTarget),
    .pc    (pc)
  );

  assign imem_addr   = pc;
  assign instr       = instr_q;
  assign instr_pc    = instrPc_q;
  assign instr_valid = instrValid_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: transaction-level model plus directed scenarios.
module tb_fetch_sequencer;

  localparam int TMO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, branch_valid, stall, imem_ack;
  logic [31:0] branch_target, imem_rdata;
  logic        imem_req, instr_valid, fetch_err;
  logic [31:0] imem_addr, instr, instr_pc, pc;

  logic        wReq, wValid, wErr;
  logic [31:0] wAddr, wInstr, wInstrPc, wPc;

  int checks = 0;
  int errors = 0;

  fetch_sequencer #(.RESET_VECTOR(32'h0000_0000), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .branch_valid(branch_valid), .branch_target(branch_target),
    .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .pc(pc), .fetch_err(fetch_err)
  );

  // Second instance starting at the top of the address space, always acked.
  fetch_sequencer #(.RESET_VECTOR(32'hFFFF_FFFC), .TIMEOUT_CYCLES(TMO)) dutWrap (
    .clk(clk), .reset(reset), .branch_valid(1'b0), .branch_target(32'h0),
    .stall(1'b0), .imem_req(wReq), .imem_addr(wAddr), .imem_ack(1'b1),
    .imem_rdata(imem_rdata), .instr_valid(wValid), .instr(wInstr), .instr_pc(wInstrPc),
    .pc(wPc), .fetch_err(wErr)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One cycle of inputs; returns 1 time unit after the edge that consumed them.
  task automatic applyStimulus(input logic rst, input logic bv, input logic [31:0] bt,
                               input logic st, input logic ack, input logic [31:0] rd);
    reset = rst; branch_valid = bv; branch_target = bt;
    stall = st; imem_ack = ack; imem_rdata = rd;
    @(posedge clk);
    #1;
  endtask

  // Transaction-level model: a request is outstanding with an age, a delivered word
  // is held, and at most one redirect target may be queued behind the outstanding request.
  logic        checkEn = 1'b0;
  logic        mStartup, mReqActive, mDelivered, mErr;
  int          mReqAge;
  logic [31:0] mPc, mInstr, mInstrPc;
  logic [31:0] mRedir[$];

  function automatic void restart(input logic [31:0] addr);
    mPc        = addr;
    mReqActive = 1'b1;
    mReqAge    = 0;
    mDelivered = 1'b0;
    mRedir.delete();
  endfunction

  always @(posedge clk) begin
    logic [31:0] tgt;
    logic        tmo;
    tgt = branch_target & 32'hFFFF_FFFC;
    if (reset) begin
      checkEn = 1'b1; mStartup = 1'b1; mReqActive = 1'b0; mDelivered = 1'b0;
      mErr = 1'b0; mReqAge = 0; mPc = 32'h0; mInstr = 32'h0; mInstrPc = 32'h0;
      mRedir.delete();
    end else if (checkEn) begin
      mErr = 1'b0;
`ifdef FETCH_TIMEOUT_EN
      tmo = mReqActive && (mReqAge == TMO);
`else
      tmo = 1'b0;
`endif
      if (mStartup) begin
        mStartup = 1'b0;
        restart(mPc);
      end else if (mReqActive) begin
        if (branch_valid && (imem_ack || mReqAge == 0)) begin
          restart(tgt);
        end else begin
          if (branch_valid) mRedir = {tgt};
          if (imem_ack) begin
            if (mRedir.size() > 0) restart(mRedir.pop_front());
            else begin
              mInstr = imem_rdata; mInstrPc = mPc; mPc = mPc + 32'd4;
              mReqActive = 1'b0; mDelivered = 1'b1;
            end
          end else if (tmo) begin
            mErr = 1'b1;
            if (mRedir.size() > 0) restart(mRedir.pop_front());
            else restart(mPc);
          end else begin
            mReqAge++;
          end
        end
      end else if (mDelivered) begin
        if (branch_valid) restart(tgt);
        else if (!stall) restart(mPc);
      end
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("model imem_req", 32'(imem_req), 32'(mReqActive));
      if (mReqActive) checkOutput("model imem_addr", imem_addr, mPc);
      checkOutput("model pc", pc, mPc);
      checkOutput("model instr_valid", 32'(instr_valid), 32'(mDelivered));
      checkOutput("model instr", instr, mInstr);
      checkOutput("model instr_pc", instr_pc, mInstrPc);
      checkOutput("model fetch_err", 32'(fetch_err), 32'(mErr));
    end
  end

  initial begin
    logic [31:0] expPc[4];
    logic [31:0] expWrapPc[4];
    logic [31:0] rd;
    int          reqCycles;
    int          errPulses;

    expPc     = '{32'h0, 32'h4, 32'h8, 32'hC};
    expWrapPc = '{32'hFFFF_FFFC, 32'h0, 32'h4, 32'h8};
    reset = 1'b1; branch_valid = 1'b0; branch_target = 32'h0;
    stall = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;

    $display("[TB] reset and back-to-back fetches");
    repeat (3) applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("reset instr_valid", 32'(instr_valid), 32'h0);
    checkOutput("reset imem_req", 32'(imem_req), 32'h0);
    checkOutput("reset pc", pc, 32'h0);
    checkOutput("reset wrap pc", wPc, 32'hFFFF_FFFC);
    applyStimulus(0, 0, 0, 0, 1, 32'h0);
    checkOutput("startup imem_req", 32'(imem_req), 32'h1);
    for (int i = 0; i < 4; i++) begin
      rd = 32'hA000_0000 + 32'(i);
      applyStimulus(0, 0, 0, 0, 1, rd);
      checkOutput("seq instr_valid", 32'(instr_valid), 32'h1);
      checkOutput("seq instr_pc", instr_pc, expPc[i]);
      checkOutput("seq instr", instr, rd);
      checkOutput("wrap instr_pc", wInstrPc, expWrapPc[i]);
      checkOutput("wrap instr", wInstr, rd);
      checkOutput("wrap valid", 32'(wValid), 32'h1);
      applyStimulus(0, 0, 0, 0, 1, 32'h0);
      checkOutput("seq gap instr_valid", 32'(instr_valid), 32'h0);
    end
    checkOutput("wrap imem_req", 32'(wReq), 32'h1);
    checkOutput("wrap imem_addr", wAddr, 32'hC);
    checkOutput("wrap fetch_err", 32'(wErr), 32'h0);

    $display("[TB] delayed ack");
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    reqCycles = 0;
    for (int i = 0; i < 4; i++) begin
      if (imem_req && imem_addr == 32'h0) reqCycles++;
      if (i < 3) applyStimulus(0, 0, 0, 0, 0, 0);
    end
    applyStimulus(0, 0, 0, 0, 1, 32'hE3A0_1001);
    checkOutput("delay req cycles", 32'(reqCycles), 32'd4);
    checkOutput("delay instr", instr, 32'hE3A0_1001);
    checkOutput("delay instr_pc", instr_pc, 32'h0);
    checkOutput("delay instr_valid", 32'(instr_valid), 32'h1);

    $display("[TB] stall in HOLD");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 0, 1, 1, 32'h5555_5555);
      checkOutput("stall instr", instr, 32'hE3A0_1001);
      checkOutput("stall instr_valid", 32'(instr_valid), 32'h1);
      checkOutput("stall imem_req", 32'(imem_req), 32'h0);
      checkOutput("stall pc", pc, 32'h4);
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("unstall imem_addr", imem_addr, 32'h4);

    $display("[TB] redirect during WAIT");
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 32'h0000_0100, 0, 0, 0);
    checkOutput("pending imem_addr", imem_addr, 32'h4);
    applyStimulus(0, 0, 0, 0, 1, 32'hDEAD_BEEF);
    checkOutput("discard instr_valid", 32'(instr_valid), 32'h0);
    checkOutput("redirect imem_addr", imem_addr, 32'h100);
    applyStimulus(0, 0, 0, 0, 1, 32'h1111_2222);
    checkOutput("redirect instr_pc", instr_pc, 32'h100);

    $display("[TB] branch with ack, branch over stall");
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 32'h0000_0203, 0, 1, 32'h3333_3333);
    checkOutput("branch+ack instr_valid", 32'(instr_valid), 32'h0);
    checkOutput("branch+ack imem_addr", imem_addr, 32'h200);
    applyStimulus(0, 0, 0, 0, 1, 32'h4444_4444);
    checkOutput("aligned instr_pc", instr_pc, 32'h200);
    applyStimulus(0, 1, 32'h0000_0040, 1, 0, 0);
    checkOutput("branch>stall instr_valid", 32'(instr_valid), 32'h0);
    checkOutput("branch>stall imem_addr", imem_addr, 32'h40);

    $display("[TB] reset during WAIT");
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 1, 32'h7777_7777);
    checkOutput("midreset imem_req", 32'(imem_req), 32'h0);
    checkOutput("midreset instr", instr, 32'h0);
    applyStimulus(0, 0, 0, 0, 1, 32'h8888_8888);
    checkOutput("late ack instr_valid", 32'(instr_valid), 32'h0);
    checkOutput("late ack imem_addr", imem_addr, 32'h0);

    $display("[TB] no ack for 15 cycles");
    errPulses = 0;
    for (int i = 0; i < 15; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      if (fetch_err) errPulses++;
    end
`ifdef FETCH_TIMEOUT_EN
    checkOutput("timeout pulses", 32'(errPulses), 32'd3);
`else
    checkOutput("timeout pulses", 32'(errPulses), 32'd0);
`endif
    checkOutput("timeout pc", pc, 32'h0);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
